// File: rtl/craft_pkg.sv
// Shared CRAFT constants and the SubCells sequencer state type.
package craft_pkg;

   localparam int unsigned CRAFT_STATE_W = 64;
   localparam int unsigned CRAFT_NIBBLES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } craft_subcells_state_t;

endpackage

// File: rtl/craft_sbox.sv
// CRAFT 4-bit S-box (an involution).
module craft_sbox (
   input  logic [3:0] in_nib,
   output logic [3:0] out_nib
);

   always_comb begin
      out_nib = 4'h0;
      unique case (in_nib)
         4'h0: out_nib = 4'hc;
         4'h1: out_nib = 4'ha;
         4'h2: out_nib = 4'hd;
         4'h3: out_nib = 4'h3;
         4'h4: out_nib = 4'he;
         4'h5: out_nib = 4'hb;
         4'h6: out_nib = 4'hf;
         4'h7: out_nib = 4'h7;
         4'h8: out_nib = 4'h8;
         4'h9: out_nib = 4'h9;
         4'ha: out_nib = 4'h1;
         4'hb: out_nib = 4'h5;
         4'hc: out_nib = 4'h0;
         4'hd: out_nib = 4'h2;
         4'he: out_nib = 4'h4;
         4'hf: out_nib = 4'h6;
         default: out_nib = 4'h0;
      endcase
   end

endmodule

// File: rtl/craft_subcells_sched.sv
// CRAFT SubCells sequencer: LANES shared S-boxes swept over the 16 state nibbles.
// Optional S-box output register stage enabled by `define CRAFT_SUBCELLS_PIPE_EN.
module craft_subcells_sched
   import craft_pkg::*;
#(
   parameter int unsigned LANES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CRAFT_STATE_W-1:0] in_state,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CRAFT_STATE_W-1:0] out_state,
   output logic                     busy
);

   localparam int unsigned BEATS  = (LANES == 0) ? 1 : CRAFT_NIBBLES / LANES;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("craft_subcells_sched: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   craft_subcells_state_t     state_q, state_d;
   logic [CRAFT_STATE_W-1:0]  work_q, work_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;

   logic [3:0]                sbox_in  [LANES];
   logic [3:0]                sbox_out [LANES];
   logic [LANES*4-1:0]        sbox_flat;

`ifdef CRAFT_SUBCELLS_PIPE_EN
   logic                      pv_q, pv_d;
   logic [BEAT_W-1:0]         pbeat_q, pbeat_d;
   logic [LANES*4-1:0]        pdata_q, pdata_d;
   logic                      issued_q, issued_d;
`endif

   // Lane j always reads nibble beat*LANES+j of the working register.
   always_comb begin
      sbox_flat = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         sbox_in[j]          = work_q[4*(32'(beat_q)*LANES + j) +: 4];
         sbox_flat[4*j +: 4] = sbox_out[j];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      craft_sbox u_sbox (
         .in_nib  (sbox_in[g]),
         .out_nib (sbox_out[g])
      );
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      beat_d  = beat_q;
`ifdef CRAFT_SUBCELLS_PIPE_EN
      pv_d     = 1'b0;
      pbeat_d  = pbeat_q;
      pdata_d  = pdata_q;
      issued_d = issued_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_state;
               beat_d  = '0;
               state_d = BUSY;
`ifdef CRAFT_SUBCELLS_PIPE_EN
               issued_d = 1'b0;
`endif
            end
         end
         BUSY: begin
`ifdef CRAFT_SUBCELLS_PIPE_EN
            // Read of beat k overlaps the write-back of beat k-1; they touch disjoint nibbles.
            if (!issued_q) begin
               pv_d    = 1'b1;
               pbeat_d = beat_q;
               pdata_d = sbox_flat;
               if (beat_q == LAST_BEAT) issued_d = 1'b1;
               else                     beat_d   = beat_q + BEAT_W'(1);
            end
            if (pv_q) begin
               for (int unsigned j = 0; j < LANES; j++) begin
                  work_d[4*(32'(pbeat_q)*LANES + j) +: 4] = pdata_q[4*j +: 4];
               end
               if (pbeat_q == LAST_BEAT) state_d = DONE;
            end
`else
            for (int unsigned j = 0; j < LANES; j++) begin
               work_d[4*(32'(beat_q)*LANES + j) +: 4] = sbox_flat[4*j +: 4];
            end
            if (beat_q == LAST_BEAT) state_d = DONE;
            else                     beat_d  = beat_q + BEAT_W'(1);
`endif
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         beat_d  = '0;
`ifdef CRAFT_SUBCELLS_PIPE_EN
         pv_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         work_q   <= '0;
         beat_q   <= '0;
`ifdef CRAFT_SUBCELLS_PIPE_EN
         pv_q     <= 1'b0;
         pbeat_q  <= '0;
         pdata_q  <= '0;
         issued_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         beat_q   <= beat_d;
`ifdef CRAFT_SUBCELLS_PIPE_EN
         pv_q     <= pv_d;
         pbeat_q  <= pbeat_d;
         pdata_q  <= pdata_d;
         issued_q <= issued_d;
`endif
      end
   end

   // in_ready is held low for as long as reset is asserted.
   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == BUSY) || (state_q == DONE);
   assign out_state = work_q;

endmodule
